// File: rtl/rx_stream_arbiter.sv
// rtl/rx_stream_arbiter.sv - packet-level round-robin arbiter feeding the rxd/rx_dv input
//
// Purpose:
//   Shares one byte-wide rxd/rx_dv stream between N_REQ byte-stream sources.
//   A source is granted for a whole packet. The grant ends on its last beat, or is
//   forced off after MAX_BEATS beats. Beats are forwarded with one registered cycle
//   of latency. IFG idle cycles are enforced after every packet.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   src_data   in   8*N_REQ  source byte i at [8*i+7:8*i]
//   src_dv     in   N_REQ    source i presents a valid beat
//   src_last   in   N_REQ    last beat of packet (qualified by src_dv)
//   src_rdy    out  N_REQ    beat accepted when src_dv[i] & src_rdy[i]
//   rxd        out  8        forwarded byte
//   rx_dv      out  1        rxd valid
//   grant      out  N_REQ    one-hot current owner, 0 when none
//   busy       out  1        arbiter not in IDLE
//   trunc_err  out  1        pulse: grant force-released at MAX_BEATS without src_last

module rx_stream_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 64,
  parameter int IFG       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] src_data,
  input  logic [N_REQ-1:0]   src_dv,
  input  logic [N_REQ-1:0]   src_last,
  output logic [N_REQ-1:0]   src_rdy,
  output logic [7:0]         rxd,
  output logic               rx_dv,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               trunc_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BEATS);
  // Keep the gap counter at least one bit wide so IFG=0 still elaborates.
  localparam int GW = (IFG > 0) ? $clog2(IFG + 1) : 1;

  localparam logic [PW-1:0] RR_RESET  = PW'(N_REQ - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BEATS - 1);
  localparam logic [GW-1:0] GAP_LAST  = (IFG > 0) ? GW'(IFG - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [PW-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [PW-1:0]      winner_q,    winner_d;
  logic [N_REQ-1:0]   grant_q,     grant_d;
  logic [BW-1:0]      beat_cnt_q,  beat_cnt_d;
  logic [GW-1:0]      gap_cnt_q,   gap_cnt_d;
  logic [7:0]         rxd_q,       rxd_d;
  logic               rx_dv_q,     rx_dv_d;
  logic               trunc_err_q, trunc_err_d;

  logic               arb_found;
  logic [PW-1:0]      arb_idx;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               accept;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int            cand;
    logic [PW-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % N_REQ;
      cand_idx = PW'(cand);
      if (!arb_found && src_dv[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Only the granted source's byte and last flag ever reach the datapath.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner_q == PW'(i)) begin
        sel_data = src_data[8*i +: 8];
        sel_last = src_last[i];
      end
    end
  end

  assign src_rdy = (state_q == ST_BUSY) ? grant_q : '0;
  assign accept  = (state_q == ST_BUSY) && ((src_dv & grant_q) != '0);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rxd_d       = rxd_q;
    rx_dv_d     = 1'b0;
    trunc_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration takes this whole cycle; no beat is accepted here.
        if (arb_found) begin
          winner_d = arb_idx;
          grant_d  = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A stalled owner just produces bubbles; the grant is held.
        if (accept) begin
          rxd_d      = sel_data;
          rx_dv_d    = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (sel_last || (beat_cnt_q == BEAT_LAST)) begin
            // Hitting the limit on a genuine last beat is not a truncation.
            trunc_err_d = !sel_last;
            rr_ptr_d    = winner_q;
            grant_d     = '0;
            beat_cnt_d  = '0;
            gap_cnt_d   = '0;
            state_d     = (IFG > 0) ? ST_GAP : ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset aborts any packet in flight; nothing is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= RR_RESET;
      winner_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rxd_q       <= '0;
      rx_dv_q     <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rxd_q       <= rxd_d;
      rx_dv_q     <= rx_dv_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign rxd       = rxd_q;
  assign rx_dv     = rx_dv_q;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign trunc_err = trunc_err_q;

endmodule
